// File: rtl/spi_rx_target.sv
// -----------------------------------------------------------------------------
// spi_rx_target
//
// SPI mode-0 target (receive-only) endpoint. The external SPI pins are
// oversampled on the system clock, serial bits are assembled into words, and
// each completed word is offered to downstream logic on a valid/ready
// interface. It is used as the loop-back receiver for the ILI9341 command
// path and as a debug capture port.
//
// Parameters:
//   DATA_W      - bits per word (bit counter is clog2(DATA_W)+1 wide)
//   SYNC_STAGES - synchronizer depth on every SPI pin, legal range 2..4
//   MSB_FIRST   - 1: first received bit lands in rx_data[DATA_W-1]
//                 0: first received bit lands in rx_data[0]
//
// Optional feature (macro SPI_RX_DC_EN):
//   Adds input spi_dc and output rx_dc. The data/command flag is sampled on
//   the last bit of each word and travels with rx_data through the same
//   holding register, hold and overrun rules.
//
// Ports:
//   clk         in   system clock, at least 4x the spi_sclk frequency
//   rst         in   synchronous active-high reset
//   spi_sclk    in   asynchronous SPI clock, idles low
//   spi_cs_n    in   asynchronous chip select, active low
//   spi_mosi    in   asynchronous serial data, sampled on sclk rising edge
//   spi_dc      in   (SPI_RX_DC_EN only) asynchronous data/command flag
//   rx_data     out  last completed word, stable while rx_valid is high
//   rx_dc       out  (SPI_RX_DC_EN only) flag belonging to rx_data
//   rx_valid    out  a word is waiting in the holding register
//   rx_ready    in   consumer takes the word when rx_valid & rx_ready
//   frame_start out  one-cycle pulse on synchronized cs_n falling edge
//   frame_err   out  one-cycle pulse when cs_n rises with a partial word
//   overrun     out  sticky: a word completed while the holding reg was full
//   ovr_clr     in   single-cycle clear of overrun
// -----------------------------------------------------------------------------
module spi_rx_target #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
`ifdef SPI_RX_DC_EN
    input  logic              spi_dc,
    output logic              rx_dc,
`endif
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_start,
    output logic              frame_err,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    // Synchronizer chains, one per pin; the top bit is the synchronized value.
    logic [SYNC_STAGES-1:0] sclkSync_q;
    logic [SYNC_STAGES-1:0] csSync_q;
    logic [SYNC_STAGES-1:0] mosiSync_q;
    logic                   sclkSynced;
    logic                   csSynced;
    logic                   mosiSynced;

    // Edge detection and the data bit that goes with each sclk edge.
    logic sclkPrev_q;
    logic csPrev_q;
    logic sclkRise_q;
    logic csFall_q;
    logic csRise_q;
    logic mosiSample_q;

    // Receive state machine.
    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [CNT_W-1:0]  bitCnt_q;
    logic [CNT_W-1:0]  bitCnt_d;
    logic              frameStart_q;
    logic              frameStart_d;
    logic              frameErr_q;
    logic              frameErr_d;

    // Holding register and handshake.
    logic [DATA_W-1:0] rxData_q;
    logic              rxValid_q;
    logic              overrun_q;
    logic              commit;
    logic              loadWord;
    logic              ovrEvent;

`ifdef SPI_RX_DC_EN
    logic [SYNC_STAGES-1:0] dcSync_q;
    logic                   dcSynced;
    logic                   dcSample_q;
    logic                   dcWord_q;
    logic                   rxDc_q;
`endif

    assign sclkSynced = sclkSync_q[SYNC_STAGES-1];
    assign csSynced   = csSync_q[SYNC_STAGES-1];
    assign mosiSynced = mosiSync_q[SYNC_STAGES-1];

    // Pin synchronizers. Reset loads the idle levels of the bus so that a
    // reset never manufactures a false cs_n or sclk edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclkSync_q <= '0;
            csSync_q   <= '1;
            mosiSync_q <= '0;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], spi_sclk};
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    // Edge detectors on the synchronized pins. The edge pulses are registered
    // together with the matching mosi value, so the state machine always sees
    // a bit and its strobe in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclkPrev_q   <= 1'b0;
            csPrev_q     <= 1'b1;
            sclkRise_q   <= 1'b0;
            csFall_q     <= 1'b0;
            csRise_q     <= 1'b0;
            mosiSample_q <= 1'b0;
        end else begin
            sclkPrev_q   <= sclkSynced;
            csPrev_q     <= csSynced;
            sclkRise_q   <= sclkSynced & ~sclkPrev_q;
            csFall_q     <= ~csSynced & csPrev_q;
            csRise_q     <= csSynced & ~csPrev_q;
            mosiSample_q <= mosiSynced;
        end
    end

    // State register for the receive FSM, including the registered frame
    // pulses so that frame_start and frame_err are glitch-free outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bitCnt_q     <= '0;
            frameStart_q <= 1'b0;
            frameErr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bitCnt_q     <= bitCnt_d;
            frameStart_q <= frameStart_d;
            frameErr_q   <= frameErr_d;
        end
    end

    // Next-state logic. A cs_n rise in SHIFT takes priority over an sclk
    // edge: once the target is deselected nothing more belongs to the word.
    // COMMIT lasts one cycle and decides from the live cs_n level whether the
    // frame continues, which also swallows a cs_n rise landing in COMMIT.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bitCnt_d     = bitCnt_q;
        frameStart_d = 1'b0;
        frameErr_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (csFall_q) begin
                    frameStart_d = 1'b1;
                    bitCnt_d     = '0;
                    shift_d      = '0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                if (csRise_q) begin
                    frameErr_d = (bitCnt_q != '0);
                    bitCnt_d   = '0;
                    shift_d    = '0;
                    state_d    = IDLE;
                end else if (sclkRise_q) begin
                    if (MSB_FIRST) begin
                        shift_d = {shift_q[DATA_W-2:0], mosiSample_q};
                    end else begin
                        shift_d = {mosiSample_q, shift_q[DATA_W-1:1]};
                    end
                    bitCnt_d = bitCnt_q + CNT_W'(1);
                    if (bitCnt_q == LAST_BIT) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                bitCnt_d = '0;
                state_d  = csSynced ? IDLE : SHIFT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign commit   = (state_q == COMMIT);
    assign loadWord = commit & (~rxValid_q | rx_ready);
    assign ovrEvent = commit & rxValid_q & ~rx_ready;

    // Holding register. A commit is accepted when the register is empty or
    // is being emptied in the same cycle; otherwise the new word is dropped
    // and overrun records the loss. A new overrun event beats ovr_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxData_q  <= '0;
            rxValid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (loadWord) begin
                rxData_q  <= shift_q;
                rxValid_q <= 1'b1;
            end else if (!commit && rxValid_q && rx_ready) begin
                rxValid_q <= 1'b0;
            end
            overrun_q <= ovrEvent | (overrun_q & ~ovr_clr);
        end
    end

`ifdef SPI_RX_DC_EN
    assign dcSynced = dcSync_q[SYNC_STAGES-1];

    // Data/command flag path. The flag is sampled alongside mosi; the value
    // captured on the last sclk rise of a word is the one kept, because every
    // bit overwrites the previous capture. It then follows rx_data exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            dcSync_q   <= '0;
            dcSample_q <= 1'b0;
            dcWord_q   <= 1'b0;
            rxDc_q     <= 1'b0;
        end else begin
            dcSync_q   <= {dcSync_q[SYNC_STAGES-2:0], spi_dc};
            dcSample_q <= dcSynced;
            if (state_q == SHIFT && sclkRise_q && !csRise_q) begin
                dcWord_q <= dcSample_q;
            end
            if (loadWord) begin
                rxDc_q <= dcWord_q;
            end
        end
    end

    assign rx_dc = rxDc_q;
`endif

    assign rx_data     = rxData_q;
    assign rx_valid    = rxValid_q;
    assign frame_start = frameStart_q;
    assign frame_err   = frameErr_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/spi_rx_target.md
Name: spi_rx_target

Overview:
- SPI mode-0 target (receive) endpoint, the other end of the link driven by the team's SPI master shifter (cs_n/sclk/mosi).
- Oversamples the external SPI pins on the system clock and assembles bytes.
- Presents each byte on a valid/ready interface to downstream logic such as a command decoder or loop-back checker.
- Used as the bench/loop-back receiver for the ILI9341 command path and as a debug capture port.

Parameters:
- DATA_W, 8, bits per word; bit counter width is clog2(DATA_W)+1.
- SYNC_STAGES, 2, flip-flop stages on each of spi_sclk, spi_cs_n, spi_mosi; legal range 2..4.
- MSB_FIRST, 1, 1 = first received bit lands in rx_data[DATA_W-1]; 0 = first bit lands in rx_data[0].

Ports:
- clk  input  1  system clock; must be at least 4x the spi_sclk frequency.
- rst  input  1  synchronous, active-high reset.
- spi_sclk  input  1  asynchronous SPI clock from master; idles low (mode 0).
- spi_cs_n  input  1  asynchronous chip select, active low.
- spi_mosi  input  1  asynchronous serial data; sampled on sclk rising edge.
- rx_data  output  DATA_W  last completed word; held stable while rx_valid=1.
- rx_valid  output  1  word available.
- rx_ready  input  1  consumer accepts the word when rx_valid & rx_ready on a clk edge.
- frame_start  output  1  one-cycle pulse on synchronized cs_n falling edge.
- frame_err  output  1  one-cycle pulse when cs_n deasserts with a partial word (bit_cnt not 0).
- overrun  output  1  sticky; set when a word completes while the holding register is still full.
- ovr_clr  input  1  single-cycle clear of overrun.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; shift register, bit_cnt and rx_data cleared to 0.
  - rx_valid=0, frame_start=0, frame_err=0, overrun=0.
  - All synchronizer flops are set to their idle values: sclk=0, cs_n=1, mosi=0.
  - Reset mid-byte discards the partial word and any held word.
- Synchronization and edge detection:
  - Each pin passes through SYNC_STAGES flops.
  - sclk_rise = synced sclk & ~previous synced sclk. cs_fall and cs_rise are derived the same way.
- State machine: IDLE, SHIFT, COMMIT.
  - IDLE: waits for cs_fall. On cs_fall, pulse frame_start, clear bit_cnt, go to SHIFT.
  - SHIFT, on sclk_rise: shift synced mosi in (direction set by MSB_FIRST) and increment bit_cnt. When bit_cnt reaches DATA_W-1 and this sample completes the word, go to COMMIT.
  - SHIFT, on cs_rise: if bit_cnt != 0, pulse frame_err and discard the partial word. Go to IDLE in either case.
  - COMMIT (exactly one cycle): write the word to the holding register, clear bit_cnt. Go to SHIFT if cs_n is still low, otherwise go to IDLE.
- Latency: rx_valid rises on the clk edge SYNC_STAGES+2 cycles after the first clk edge at which raw spi_sclk is high for the last bit.
- Holding register and handshake:
  - At COMMIT with rx_valid=0: load rx_data and set rx_valid=1.
  - At COMMIT with rx_valid=1 and rx_ready=1 in the same cycle: load the new word; rx_valid stays 1; no overrun.
  - At COMMIT with rx_valid=1 and rx_ready=0: keep the old rx_data, drop the new word, set overrun.
  - No COMMIT with rx_valid & rx_ready: clear rx_valid.
- overrun: once set, holds until rst or ovr_clr. If ovr_clr and a new overrun event occur in the same cycle, overrun remains set.
- Ignored inputs: sclk edges while in IDLE (cs_n high) are ignored. A cs_fall while in SHIFT cannot occur; a glitch shorter than the synchronizer depth is not detected.
- Back-to-back words within one frame need no gap beyond COMMIT. COMMIT may not coincide with an sclk_rise, which the 4x clock-ratio rule guarantees.
- Bit counter wraps only through COMMIT, never by arithmetic overflow.

Optional Feature:
- Macro: SPI_RX_DC_EN.
- When defined:
  - Extra input spi_dc (1 bit, asynchronous, synchronized like mosi).
  - Extra output rx_dc (1 bit).
  - The synchronized spi_dc value is captured at the sclk_rise of the last bit of each word and loaded into rx_dc alongside rx_data, following identical hold and overrun rules.
  - rx_dc resets to 0.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single byte: cs_n low, send 0xA5 at sclk=clk/8, MSB_FIRST=1 -> one frame_start pulse; rx_data=0xA5 with rx_valid at the specified latency; no frame_err.
- Back-to-back bytes with rx_ready tied 1: 0x3C then 0xC3 in one frame -> two accepted words in order; overrun=0.
- Overrun: send 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x11 and overrun=1. Pulse ovr_clr -> overrun=0 while rx_valid stays 1.
- Abort: raise cs_n after 5 bits of 0xFF -> one frame_err pulse; rx_valid stays 0. The next full byte 0x5A is received correctly.
- Reset mid-byte: assert rst after 3 bits -> all outputs 0. A subsequent byte 0x81 is received intact.
- SPI_RX_DC_EN: send 0x2C with dc=0, then 0x00 with dc=1 -> rx_dc values are 0 then 1, aligned with rx_data.
